// File: rtl/subleq_seq_if.sv
// RAM bus between the SUBLEQ sequencer (master) and the 8x256 RAM (slave).
// Controls are active-low; the shared data pin is split into dat_o/dat_oe/dat_i.
interface subleq_seq_if;
  logic       ram_ope;
  logic       ram_ctl;
  logic       ram_ena;
  logic [7:0] ram_adr;
  logic [7:0] ram_dat_o;
  logic       ram_dat_oe;
  logic [7:0] ram_dat_i;

  modport master (
    output ram_ope, ram_ctl, ram_ena, ram_adr, ram_dat_o, ram_dat_oe,
    input  ram_dat_i
  );

  modport slave (
    input  ram_ope, ram_ctl, ram_ena, ram_adr, ram_dat_o, ram_dat_oe,
    output ram_dat_i
  );
endinterface

// File: rtl/subleq_seq.sv
// SUBLEQ instruction sequencer: fetches A,B,C, writes mem[B]-mem[A] back, branches on <= 0.
// Optional single-step mode is enabled by defining SUBLEQ_STEP_EN (adds the step input and PAUSE state).
module subleq_seq #(
  parameter logic [7:0] START_PC  = 8'h00,
  parameter logic [7:0] HALT_ADDR = 8'hFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
`ifdef SUBLEQ_STEP_EN
  input  logic         step,
`endif
  subleq_seq_if.master ram,
  output logic [7:0]   pc,
  output logic         busy,
  output logic         halted,
  output logic         retire
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_READ_A,
    S_READ_B,
    S_WR_SETUP,
    S_WR_STROBE,
    S_WR_HOLD,
    S_HALT
`ifdef SUBLEQ_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t     state_q;
  logic [7:0] pc_q;
  logic [7:0] ra_q, rb_q, rc_q;
  logic [7:0] va_q, vb_q;
  logic [7:0] adr_q;
  logic [7:0] datOut_q;
  logic       datOe_q;
  logic       ope_q, ctl_q, ena_q;
  logic       busy_q, halted_q, retire_q;

  logic [7:0] result_d;
  logic       leq_d;
  logic       halt_d;
  logic [7:0] nextPc_d;

  // Branch decision from the operand values; equals the data already on the write bus.
  always_comb begin
    result_d = vb_q - va_q;
    leq_d    = (result_d == 8'h00) | result_d[7];
    halt_d   = leq_d & (rc_q == HALT_ADDR);
    nextPc_d = leq_d ? rc_q : pc_q + 8'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= START_PC;
      ra_q     <= 8'h00;
      rb_q     <= 8'h00;
      rc_q     <= 8'h00;
      va_q     <= 8'h00;
      vb_q     <= 8'h00;
      adr_q    <= 8'h00;
      datOut_q <= 8'h00;
      datOe_q  <= 1'b0;
      ope_q    <= 1'b1;
      ctl_q    <= 1'b1;
      ena_q    <= 1'b1;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (run) begin
            state_q  <= S_FETCH_A;
            pc_q     <= START_PC;
            adr_q    <= START_PC;
            ope_q    <= 1'b0;
            ena_q    <= 1'b0;
            ctl_q    <= 1'b1;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        S_FETCH_A: begin
          ra_q    <= ram.ram_dat_i;
          adr_q   <= pc_q + 8'd1;
          state_q <= S_FETCH_B;
        end
        S_FETCH_B: begin
          rb_q    <= ram.ram_dat_i;
          adr_q   <= pc_q + 8'd2;
          state_q <= S_FETCH_C;
        end
        S_FETCH_C: begin
          rc_q    <= ram.ram_dat_i;
          adr_q   <= ra_q;
          state_q <= S_READ_A;
        end
        S_READ_A: begin
          va_q    <= ram.ram_dat_i;
          adr_q   <= rb_q;
          state_q <= S_READ_B;
        end
        // Write data must be registered on entry to WR_SETUP, so subtract straight from the bus.
        S_READ_B: begin
          vb_q     <= ram.ram_dat_i;
          adr_q    <= rb_q;
          datOut_q <= ram.ram_dat_i - va_q;
          datOe_q  <= 1'b1;
          ope_q    <= 1'b1;
          state_q  <= S_WR_SETUP;
        end
        S_WR_SETUP: begin
          ctl_q   <= 1'b0;
          state_q <= S_WR_STROBE;
        end
        S_WR_STROBE: begin
          ctl_q    <= 1'b1;
          retire_q <= 1'b1;
          state_q  <= S_WR_HOLD;
        end
        S_WR_HOLD: begin
          datOe_q <= 1'b0;
          pc_q    <= nextPc_d;
          if (halt_d) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
            busy_q   <= 1'b0;
            ena_q    <= 1'b1;
          end else begin
`ifdef SUBLEQ_STEP_EN
            state_q <= S_PAUSE;
            busy_q  <= 1'b0;
            ena_q   <= 1'b1;
`else
            state_q <= S_FETCH_A;
            adr_q   <= nextPc_d;
            ope_q   <= 1'b0;
`endif
          end
        end
`ifdef SUBLEQ_STEP_EN
        S_PAUSE: begin
          if (step) begin
            state_q <= S_FETCH_A;
            adr_q   <= pc_q;
            ope_q   <= 1'b0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          ope_q   <= 1'b1;
          ctl_q   <= 1'b1;
          ena_q   <= 1'b1;
          datOe_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram.ram_ope    = ope_q;
  assign ram.ram_ctl    = ctl_q;
  assign ram.ram_ena    = ena_q;
  assign ram.ram_adr    = adr_q;
  assign ram.ram_dat_o  = datOut_q;
  assign ram.ram_dat_oe = datOe_q;
  assign pc             = pc_q;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign retire         = retire_q;

endmodule

// File: tb/tb_subleq_seq.sv
// Scoreboard bench for subleq_seq: a behavioural RAM, an instruction-level SUBLEQ model
// feeding an expectation queue, and a retire-driven monitor. Works with or without SUBLEQ_STEP_EN.
module tb_subleq_seq;
  localparam logic [7:0] START = 8'h00;

  typedef struct {
    logic [7:0] wrAdr;
    logic [7:0] wrData;
    logic [7:0] nextPc;
    logic       halt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] pc;
  logic       busy, halted, retire;
`ifdef SUBLEQ_STEP_EN
  logic       step = 1'b0;
`endif

  subleq_seq_if ramIf();

  subleq_seq #(.START_PC(START), .HALT_ADDR(8'hFF)) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
`ifdef SUBLEQ_STEP_EN
    .step   (step),
`endif
    .ram    (ramIf.master),
    .pc     (pc),
    .busy   (busy),
    .halted (halted),
    .retire (retire)
  );

  always #5 clk = ~clk;

  exp_t       expQ[$];
  logic [7:0] mem[256];
  logic [7:0] img[256];
  logic [7:0] refMem[256];
  logic       loadStrobe = 1'b0;
  int passCount = 0;
  int checkCount = 0;
  int cycleCnt = 0;
  int retiredCnt = 0;
  int lastRetireCycle = 0;
  int ctlFalls = 0;
  logic [7:0] lastFallAdr = 8'h00;

  // Behavioural RAM: asynchronous read while enabled for output, write on the falling edge of ctl.
  always @(negedge ramIf.ram_ctl or posedge loadStrobe) begin
    if (loadStrobe) begin
      for (int i = 0; i < 256; i++) mem[i] = img[i];
    end else if (!ramIf.ram_ena) begin
      mem[ramIf.ram_adr] = ramIf.ram_dat_o;
    end
  end

  assign ramIf.ram_dat_i = (!ramIf.ram_ena && !ramIf.ram_ope) ? mem[ramIf.ram_adr] : 8'h00;

  always @(posedge clk) cycleCnt++;

  always @(negedge ramIf.ram_ctl) begin
    ctlFalls++;
    lastFallAdr = ramIf.ram_adr;
  end

`ifdef SUBLEQ_STEP_EN
  always @(negedge clk) step = !rst && !busy && !halted;
`endif

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
  endtask

  always @(negedge clk) begin
    if (!rst) checkOutput("bus_ope_with_oe", int'(!ramIf.ram_ope && ramIf.ram_dat_oe), 0);
  end

  // Monitor: every retire pulse pops one expected instruction result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && retire) begin
        lastRetireCycle = cycleCnt;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_retire", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("write_addr", int'(ramIf.ram_adr), int'(e.wrAdr));
          checkOutput("write_data", int'(ramIf.ram_dat_o), int'(e.wrData));
          @(negedge clk);
          checkOutput("next_pc", int'(pc), int'(e.nextPc));
          checkOutput("halted", int'(halted), int'(e.halt));
          retiredCnt++;
        end
      end
    end
  end

  // Instruction-level model: executes from START, pushing one expectation per instruction.
  task automatic modelRun(input int maxInstr, output int n, output bit halts);
    logic [7:0] p, a, b, c, res;
    exp_t e;
    p = START;
    n = 0;
    halts = 1'b0;
    while (n < maxInstr && !halts) begin
      a = refMem[p];
      b = refMem[p + 8'd1];
      c = refMem[p + 8'd2];
      res = refMem[b] - refMem[a];
      refMem[b] = res;
      e.wrAdr  = b;
      e.wrData = res;
      e.nextPc = ($signed(res) <= 0) ? c : p + 8'd3;
      e.halt   = ($signed(res) <= 0) && (c == 8'hFF);
      expQ.push_back(e);
      n++;
      halts = e.halt;
      p = e.nextPc;
    end
  endtask

  task automatic loadRam();
    img = refMem;
    loadStrobe = 1'b1;
    #1 loadStrobe = 1'b0;
  endtask

  task automatic memCheck(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) bad++;
    checkOutput(name, bad, 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
  endtask

  task automatic applyStimulus(input int maxInstr, output int startCycle, output bit halts);
    int n, base, limit;
    loadRam();
    modelRun(maxInstr, n, halts);
    base = retiredCnt;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    startCycle = cycleCnt;
    checkOutput("start_pc", int'(pc), int'(START));
    checkOutput("start_busy", int'(busy), 1);
    limit = 16 * n + 32;
    for (int k = 0; k < limit && (retiredCnt - base) < n; k++) @(negedge clk);
    checkOutput("retired_count", retiredCnt - base, n);
    memCheck("mem_image");
    if (halts) checkOutput("halt_busy", int'(busy), 0);
  endtask

  task automatic clearRef();
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
  endtask

  initial begin
    int sc, falls0;
    bit h;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_ope", int'(ramIf.ram_ope), 1);
    checkOutput("rst_ctl", int'(ramIf.ram_ctl), 1);
    checkOutput("rst_ena", int'(ramIf.ram_ena), 1);
    checkOutput("rst_oe", int'(ramIf.ram_dat_oe), 0);
    checkOutput("rst_adr", int'(ramIf.ram_adr), 0);
    checkOutput("rst_dat", int'(ramIf.ram_dat_o), 0);
    checkOutput("rst_pc", int'(pc), int'(START));
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_halted", int'(halted), 0);
    checkOutput("rst_retire", int'(retire), 0);

    // Positive result: not taken, falls through to pc+3.
    clearRef();
    refMem[0] = 8'h03; refMem[1] = 8'h04; refMem[2] = 8'h06; refMem[3] = 8'h05; refMem[4] = 8'h07;
    falls0 = ctlFalls;
    applyStimulus(1, sc, h);
    checkOutput("t1_retire_cycle", lastRetireCycle - sc + 1, 8);
    checkOutput("t1_ctl_falls", ctlFalls - falls0, 1);
    checkOutput("t1_fall_adr", int'(lastFallAdr), 8'h04);
    checkOutput("t1_mem4", int'(mem[4]), 8'h02);
    checkOutput("t1_pc", int'(pc), 8'h03);
    resetDut();

    // Zero result branching to the halt address, then restart from HALT.
    clearRef();
    refMem[0] = 8'h03; refMem[1] = 8'h03; refMem[2] = 8'hFF; refMem[3] = 8'h09;
    applyStimulus(1, sc, h);
    checkOutput("t2_mem3", int'(mem[3]), 8'h00);
    checkOutput("t2_halted", int'(halted), 1);
    checkOutput("t2_pc", int'(pc), 8'hFF);
    applyStimulus(1, sc, h);
    checkOutput("t2_rehalted", int'(halted), 1);
    resetDut();

    // Negative result: taken.
    clearRef();
    refMem[0] = 8'h03; refMem[1] = 8'h04; refMem[2] = 8'h10; refMem[3] = 8'h05; refMem[4] = 8'h02;
    applyStimulus(1, sc, h);
    checkOutput("t3_mem4", int'(mem[4]), 8'hFD);
    checkOutput("t3_pc", int'(pc), 8'h10);
    resetDut();

    // Jump to FE, then an instruction whose operands wrap through FF to 00.
    clearRef();
    refMem[8'h00] = 8'h20; refMem[8'h01] = 8'h20; refMem[8'h02] = 8'hFE;
    refMem[8'hFE] = 8'h10; refMem[8'hFF] = 8'h11;
    refMem[8'h10] = 8'h01; refMem[8'h11] = 8'h05;
    applyStimulus(2, sc, h);
    checkOutput("t4_mem11", int'(mem[8'h11]), 8'h04);
    checkOutput("t4_pc", int'(pc), 8'h01);
    resetDut();

    // Reset asserted during READ_B and held two cycles: no write may reach memory.
    clearRef();
    refMem[0] = 8'h03; refMem[1] = 8'h04; refMem[2] = 8'h06; refMem[3] = 8'h05; refMem[4] = 8'h07;
    loadRam();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t5_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("t5_async_ope", int'(ramIf.ram_ope), 1);
    checkOutput("t5_async_ena", int'(ramIf.ram_ena), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("t5_ctl", int'(ramIf.ram_ctl), 1);
    checkOutput("t5_oe", int'(ramIf.ram_dat_oe), 0);
    checkOutput("t5_pc", int'(pc), int'(START));
    checkOutput("t5_busy", int'(busy), 0);
    rst = 1'b0;
    memCheck("t5_mem_untouched");

    // Random programs, up to five instructions each.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 256; i++) refMem[i] = 8'($urandom);
      applyStimulus(int'($urandom_range(1, 5)), sc, h);
      resetDut();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/subleq_seq.md
Name: subleq_seq

Overview:
- Instruction sequencer for the SUBLEQ machine; it is the only master of the 8x256 RAM bus.
- Executes SUBLEQ A,B,C: mem[B] <= mem[B] - mem[A]; if the result is <= 0 it jumps to C, otherwise PC <= PC+3.
- Drives the RAM's active-low controls (ope, ctl, ena), address and data.
- Split data bus: the top level ties ram_dat_o/ram_dat_oe to the RAM's bidirectional dat pin.

Parameters:
START_PC, 8'h00, PC loaded when run is accepted.
HALT_ADDR, 8'hFF, a taken branch to this address halts the machine.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
run  in  1  start pulse; sampled in IDLE and HALT only.
ram_ope  out  1  RAM output enable, active-low.
ram_ctl  out  1  RAM control, 0 = write / 1 = read; the RAM writes on its falling edge.
ram_ena  out  1  RAM chip enable, active-low.
ram_adr  out  8  RAM address, registered.
ram_dat_o  out  8  write data, registered.
ram_dat_oe  out  1  drive enable for ram_dat_o onto the shared bus.
ram_dat_i  in  8  read data from the bus.
pc  out  8  current program counter.
busy  out  1  high in every state except IDLE and HALT.
halted  out  1  high in HALT.
retire  out  1  one-cycle pulse per completed instruction.

Behaviour:
- Reset (async):
  - state = IDLE.
  - ram_ope = ram_ctl = ram_ena = 1.
  - ram_dat_oe = 0; ram_adr = ram_dat_o = 0.
  - pc = START_PC.
  - busy = halted = retire = 0.
  - Internal regs ra, rb, rc, va, vb = 0.
- Reset mid-write:
  - Controls return to 1 immediately.
  - If reset arrives after ctl has fallen, the RAM write has already occurred; this is accepted.
- All outputs are registered. All state transitions occur on the rising clk edge.
- States, one cycle each unless stated:
  - IDLE: run=1 -> pc <= START_PC, go to FETCH_A.
  - FETCH_A: adr=pc, ope=0, ena=0, ctl=1; ra <= ram_dat_i at end of cycle.
  - FETCH_B: adr=pc+1; rb <= ram_dat_i.
  - FETCH_C: adr=pc+2; rc <= ram_dat_i.
  - READ_A: adr=ra; va <= ram_dat_i.
  - READ_B: adr=rb; vb <= ram_dat_i.
  - WR_SETUP:
    - adr=rb, ram_dat_o = vb - va (8-bit, mod 256).
    - oe=1, ope=1, ena=0, ctl=1.
  - WR_STROBE: ctl=0; adr, data and oe held.
  - WR_HOLD:
    - ctl=1; adr, data and oe held; retire=1.
    - leq = (res == 0) | res[7].
    - Next pc = leq ? rc : pc+3.
    - Next state = (leq & rc == HALT_ADDR) ? HALT : FETCH_A.
  - HALT: halted=1, RAM idle. run=1 -> pc <= START_PC, go to FETCH_A.
- Latency: 8 cycles per instruction. First FETCH_A is the cycle after run is sampled.
- Address arithmetic is mod 256: pc+1, pc+2, pc+3 wrap (pc = 8'hFE -> operands at FE, FF, 00; next pc 01).
- Bus rules:
  - ram_dat_oe = 1 only in the WR_* states.
  - ram_ope = 0 only in FETCH_*/READ_* states; never both at once.
  - ram_ena = 1 (disabled) in IDLE and HALT.
- A = B is legal: result 0 -> branch taken.
- run while busy is ignored.

Optional Feature:
SUBLEQ_STEP_EN:
- Defined:
  - Adds input port step (1 bit).
  - After WR_HOLD (non-halting case) the FSM enters PAUSE instead of FETCH_A.
  - In PAUSE: busy=0, RAM idle, pc shows next pc.
  - step=1 -> FETCH_A; run is ignored in PAUSE.
- Undefined: no step port, no PAUSE state; execution is free-running.

Test Plan:
- Reset during READ_B with rst held 2 cycles -> all RAM controls 1, oe 0, pc = 00, busy 0, no change to memory.
- mem[0..4] = {03,04,06,05,07}, pulse run -> mem[4] = 02, not taken, retire at cycle 8, pc = 03; bus shows ctl falling exactly once, at address 04.
- mem[0..3] = {03,03,FF,09}, run -> mem[3] = 00, taken to FF, halted = 1 and busy = 0 after 8 cycles; a second run pulse restarts at pc = 00.
- Negative result: mem[0..4] = {03,04,10,05,02} -> mem[4] = FD, pc = 10.
- Wrap: START_PC = FE, mem[FE] = 10, mem[FF] = 11, mem[00] = 20, mem[10] = 01, mem[11] = 05 -> operand fetches at FE, FF, 00; mem[11] = 04; pc = 01.
- Every cycle of every test: never ram_ope = 0 with ram_dat_oe = 1. Under SUBLEQ_STEP_EN, exactly one instruction retires per step pulse.
